// File: rtl/rob_multiport.sv
`default_nettype none
// ======================================================================
// rob_multiport : reorder buffer, N_CPL completion ports, in-order commit
//                 with exception flush.                         Rev 1.0
// ======================================================================
module rob_multiport #(
  parameter  int ROB_DEPTH = 16,
  parameter  int N_CPL     = 3,
  localparam int IDX_W     = $clog2(ROB_DEPTH),
  localparam int CNT_W     = $clog2(ROB_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alloc_valid,
  output logic                   alloc_ready,
  input  logic [31:0]            alloc_pc,
  input  logic [31:0]            alloc_addr,
  input  logic [4:0]             alloc_rd,
  input  logic [2:0]             alloc_type,
  output logic [IDX_W-1:0]       alloc_idx,
  input  logic [N_CPL-1:0]       cpl_valid,
  input  logic [N_CPL*IDX_W-1:0] cpl_idx,
  input  logic [N_CPL*32-1:0]    cpl_value,
  input  logic [N_CPL*3-1:0]     cpl_exc,
  output logic                   commit_valid,
  input  logic                   commit_ready,
  output logic [31:0]            commit_value,
  output logic [4:0]             commit_rd,
  output logic [2:0]             commit_type,
  output logic [31:0]            commit_pc,
  output logic                   flush,
  output logic [31:0]            flush_pc,
  output logic [31:0]            flush_addr,
  output logic [2:0]             flush_exc,
  output logic [CNT_W-1:0]       count,
  output logic                   empty,
  output logic                   full
);

  logic [ROB_DEPTH-1:0] valid_q, valid_d;
  logic [ROB_DEPTH-1:0] complete_q, complete_d;
  logic [2:0]           exc_q   [ROB_DEPTH];
  logic [2:0]           exc_d   [ROB_DEPTH];
  logic [31:0]          value_q [ROB_DEPTH];
  logic [31:0]          value_d [ROB_DEPTH];
  logic [31:0]          pc_q    [ROB_DEPTH];
  logic [31:0]          addr_q  [ROB_DEPTH];
  logic [4:0]           rd_q    [ROB_DEPTH];
  logic [2:0]           type_q  [ROB_DEPTH];
  logic [IDX_W-1:0]     head_q, head_d;
  logic [IDX_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic [IDX_W-1:0]     w_cpl_idx   [N_CPL];
  logic [31:0]          w_cpl_value [N_CPL];
  logic [2:0]           w_cpl_exc   [N_CPL];

  logic                 w_head_rdy;
  logic                 w_alloc_fire;
  logic                 w_commit_fire;

  for (genvar p = 0; p < N_CPL; p++) begin : g_cpl_unpack
    assign w_cpl_idx[p]   = cpl_idx[p*IDX_W +: IDX_W];
    assign w_cpl_value[p] = cpl_value[p*32 +: 32];
    assign w_cpl_exc[p]   = cpl_exc[p*3 +: 3];
  end

  // Depth need not be a power of two, so wrap is an explicit compare.
  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] ptr);
    return (ptr == IDX_W'(ROB_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign w_head_rdy    = valid_q[head_q] && complete_q[head_q];
  assign commit_valid  = w_head_rdy && (exc_q[head_q] == 3'b000);
  assign flush         = w_head_rdy && (exc_q[head_q] != 3'b000);
  assign full          = (count_q == CNT_W'(ROB_DEPTH));
  assign empty         = (count_q == '0);
  assign alloc_ready   = !full && !flush;
  assign alloc_idx     = tail_q;
  assign count         = count_q;
  assign w_alloc_fire  = alloc_valid && alloc_ready;
  assign w_commit_fire = commit_valid && commit_ready;

  assign commit_value  = value_q[head_q];
  assign commit_rd     = rd_q[head_q];
  assign commit_type   = type_q[head_q];
  assign commit_pc     = pc_q[head_q];
  assign flush_pc      = pc_q[head_q];
  assign flush_addr    = addr_q[head_q];
  assign flush_exc     = exc_q[head_q];

  always_comb begin
    valid_d    = valid_q;
    complete_d = complete_q;
    exc_d      = exc_q;
    value_d    = value_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    // Descending port order lets the lowest-numbered port win a collision.
    for (int i = 0; i < ROB_DEPTH; i++) begin
      for (int p = N_CPL - 1; p >= 0; p--) begin
        if (cpl_valid[p] && (w_cpl_idx[p] == IDX_W'(i)) && valid_q[i]) begin
          complete_d[i] = 1'b1;
          exc_d[i]      = w_cpl_exc[p];
          value_d[i]    = w_cpl_value[p];
        end
      end
    end

    if (w_commit_fire) begin
      valid_d[head_q]    = 1'b0;
      complete_d[head_q] = 1'b0;
      head_d             = ptr_inc(head_q);
    end

    if (w_alloc_fire) begin
      valid_d[tail_q]    = 1'b1;
      complete_d[tail_q] = 1'b0;
      exc_d[tail_q]      = 3'b000;
      tail_d             = ptr_inc(tail_q);
    end

    if (w_alloc_fire && !w_commit_fire) begin
      count_d = count_q + 1'b1;
    end else if (!w_alloc_fire && w_commit_fire) begin
      count_d = count_q - 1'b1;
    end

    if (flush) begin
      valid_d    = '0;
      complete_d = '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        exc_d[i] = 3'b000;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '0;
      complete_q <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        exc_q[i] <= 3'b000;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q    <= valid_d;
      complete_q <= complete_d;
      exc_q      <= exc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Payload carries no reset; entries are qualified by valid_q.
  always_ff @(posedge clk) begin
    value_q <= value_d;
    if (w_alloc_fire) begin
      pc_q[tail_q]   <= alloc_pc;
      addr_q[tail_q] <= alloc_addr;
      rd_q[tail_q]   <= alloc_rd;
      type_q[tail_q] <= alloc_type;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rob_multiport.sv
`default_nettype none
// Scoreboard bench for rob_multiport: directed scenarios on a 16-entry and a 10-entry instance.
module tb_rob_multiport;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] value;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [2:0]  typ;
  } cmt_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [2:0]  exc;
  } fl_t;

  cmt_t qa[$];
  cmt_t qb[$];
  fl_t  qf[$];
  cmt_t ea, eb;
  fl_t  ef;

  // Instance A: default depth 16
  logic        a_alloc_valid, a_alloc_ready;
  logic [31:0] a_alloc_pc, a_alloc_addr;
  logic [4:0]  a_alloc_rd;
  logic [2:0]  a_alloc_type;
  logic [3:0]  a_alloc_idx;
  logic [2:0]  a_cpl_valid;
  logic [11:0] a_cpl_idx;
  logic [95:0] a_cpl_value;
  logic [8:0]  a_cpl_exc;
  logic        a_commit_valid, a_commit_ready;
  logic [31:0] a_commit_value, a_commit_pc;
  logic [4:0]  a_commit_rd;
  logic [2:0]  a_commit_type;
  logic        a_flush;
  logic [31:0] a_flush_pc, a_flush_addr;
  logic [2:0]  a_flush_exc;
  logic [4:0]  a_count;
  logic        a_empty, a_full;

  // Instance B: depth 10
  logic        b_alloc_valid, b_alloc_ready;
  logic [31:0] b_alloc_pc, b_alloc_addr;
  logic [4:0]  b_alloc_rd;
  logic [2:0]  b_alloc_type;
  logic [3:0]  b_alloc_idx;
  logic [2:0]  b_cpl_valid;
  logic [11:0] b_cpl_idx;
  logic [95:0] b_cpl_value;
  logic [8:0]  b_cpl_exc;
  logic        b_commit_valid, b_commit_ready;
  logic [31:0] b_commit_value, b_commit_pc;
  logic [4:0]  b_commit_rd;
  logic [2:0]  b_commit_type;
  logic        b_flush;
  logic [31:0] b_flush_pc, b_flush_addr;
  logic [2:0]  b_flush_exc;
  logic [3:0]  b_count;
  logic        b_empty, b_full;

  rob_multiport u_a (
    .clk(clk), .reset(reset),
    .alloc_valid(a_alloc_valid), .alloc_ready(a_alloc_ready), .alloc_pc(a_alloc_pc),
    .alloc_addr(a_alloc_addr), .alloc_rd(a_alloc_rd), .alloc_type(a_alloc_type),
    .alloc_idx(a_alloc_idx), .cpl_valid(a_cpl_valid), .cpl_idx(a_cpl_idx),
    .cpl_value(a_cpl_value), .cpl_exc(a_cpl_exc), .commit_valid(a_commit_valid),
    .commit_ready(a_commit_ready), .commit_value(a_commit_value), .commit_rd(a_commit_rd),
    .commit_type(a_commit_type), .commit_pc(a_commit_pc), .flush(a_flush),
    .flush_pc(a_flush_pc), .flush_addr(a_flush_addr), .flush_exc(a_flush_exc),
    .count(a_count), .empty(a_empty), .full(a_full)
  );

  rob_multiport #(.ROB_DEPTH(10)) u_b (
    .clk(clk), .reset(reset),
    .alloc_valid(b_alloc_valid), .alloc_ready(b_alloc_ready), .alloc_pc(b_alloc_pc),
    .alloc_addr(b_alloc_addr), .alloc_rd(b_alloc_rd), .alloc_type(b_alloc_type),
    .alloc_idx(b_alloc_idx), .cpl_valid(b_cpl_valid), .cpl_idx(b_cpl_idx),
    .cpl_value(b_cpl_value), .cpl_exc(b_cpl_exc), .commit_valid(b_commit_valid),
    .commit_ready(b_commit_ready), .commit_value(b_commit_value), .commit_rd(b_commit_rd),
    .commit_type(b_commit_type), .commit_pc(b_commit_pc), .flush(b_flush),
    .flush_pc(b_flush_pc), .flush_addr(b_flush_addr), .flush_exc(b_flush_exc),
    .count(b_count), .empty(b_empty), .full(b_full)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT retires or flushes.
  always @(negedge clk) begin
    if (!reset) begin
      if (a_commit_valid && a_commit_ready) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_commit actual pc=%0h required none", a_commit_pc);
        end else begin
          ea = qa.pop_front();
          chk("a_commit_value", a_commit_value, ea.value);
          chk("a_commit_rd", 32'(a_commit_rd), 32'(ea.rd));
          chk("a_commit_pc", a_commit_pc, ea.pc);
          chk("a_commit_type", 32'(a_commit_type), 32'(ea.typ));
        end
      end
      if (a_flush) begin
        if (qf.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_flush actual pc=%0h required none", a_flush_pc);
        end else begin
          ef = qf.pop_front();
          chk("a_flush_pc", a_flush_pc, ef.pc);
          chk("a_flush_addr", a_flush_addr, ef.addr);
          chk("a_flush_exc", 32'(a_flush_exc), 32'(ef.exc));
        end
      end
      if (b_commit_valid && b_commit_ready) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_commit actual pc=%0h required none", b_commit_pc);
        end else begin
          eb = qb.pop_front();
          chk("b_commit_value", b_commit_value, eb.value);
          chk("b_commit_rd", 32'(b_commit_rd), 32'(eb.rd));
          chk("b_commit_pc", b_commit_pc, eb.pc);
          chk("b_commit_type", 32'(b_commit_type), 32'(eb.typ));
        end
      end
      if (b_flush) begin
        checks++; errors++;
        $display("FAIL b_unexpected_flush actual pc=%0h required none", b_flush_pc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic alloc(input bit sel, input logic [31:0] pc, input logic [31:0] addr,
                       input logic [4:0] rd, input logic [2:0] typ);
    if (!sel) begin
      a_alloc_pc = pc; a_alloc_addr = addr; a_alloc_rd = rd; a_alloc_type = typ;
      a_alloc_valid = 1'b1;
    end else begin
      b_alloc_pc = pc; b_alloc_addr = addr; b_alloc_rd = rd; b_alloc_type = typ;
      b_alloc_valid = 1'b1;
    end
    tick();
    a_alloc_valid = 1'b0;
    b_alloc_valid = 1'b0;
  endtask

  task automatic set_cpl(input bit sel, input int p, input logic [3:0] idx,
                         input logic [31:0] val, input logic [2:0] exc);
    if (!sel) begin
      a_cpl_valid[p] = 1'b1;
      a_cpl_idx[p*4 +: 4] = idx;
      a_cpl_value[p*32 +: 32] = val;
      a_cpl_exc[p*3 +: 3] = exc;
    end else begin
      b_cpl_valid[p] = 1'b1;
      b_cpl_idx[p*4 +: 4] = idx;
      b_cpl_value[p*32 +: 32] = val;
      b_cpl_exc[p*3 +: 3] = exc;
    end
  endtask

  task automatic clr_cpl();
    a_cpl_valid = '0;
    b_cpl_valid = '0;
  endtask

  task automatic cpl(input bit sel, input int p, input logic [3:0] idx,
                     input logic [31:0] val, input logic [2:0] exc);
    set_cpl(sel, p, idx, val, exc);
    tick();
    clr_cpl();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    a_alloc_valid = 0; a_alloc_pc = 0; a_alloc_addr = 0; a_alloc_rd = 0; a_alloc_type = 0;
    b_alloc_valid = 0; b_alloc_pc = 0; b_alloc_addr = 0; b_alloc_rd = 0; b_alloc_type = 0;
    a_cpl_valid = 0; a_cpl_idx = 0; a_cpl_value = 0; a_cpl_exc = 0;
    b_cpl_valid = 0; b_cpl_idx = 0; b_cpl_value = 0; b_cpl_exc = 0;
    a_commit_ready = 1'b1;
    b_commit_ready = 1'b1;
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_commit_valid", 32'(a_commit_valid), 0);
    chk("rst_flush", 32'(a_flush), 0);
    chk("rst_empty", 32'(a_empty), 1);
    chk("rst_full", 32'(a_full), 0);
    chk("rst_alloc_ready", 32'(a_alloc_ready), 1);
    chk("rst_alloc_idx", 32'(a_alloc_idx), 0);
    chk("rst_count", 32'(a_count), 0);

    // Fill with 16 allocations, then one more attempt while full
    a_alloc_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_alloc_pc = 32'h1000 + 32'(i) * 4;
      a_alloc_rd = 5'(i);
      tick();
    end
    chk("fill_full", 32'(a_full), 1);
    chk("fill_count", 32'(a_count), 16);
    chk("fill_alloc_ready", 32'(a_alloc_ready), 0);
    chk("fill_alloc_idx", 32'(a_alloc_idx), 0);
    tick();
    a_alloc_valid = 1'b0;
    chk("overfill_count", 32'(a_count), 16);
    chk("overfill_alloc_idx", 32'(a_alloc_idx), 0);
    do_reset();

    // Out-of-order completion, in-order commit
    alloc(0, 32'h10, 0, 5'd1, 3'd1);
    alloc(0, 32'h14, 0, 5'd2, 3'd2);
    alloc(0, 32'h18, 0, 5'd3, 3'd3);
    chk("ooo_alloc_idx", 32'(a_alloc_idx), 3);
    chk("ooo_count", 32'(a_count), 3);
    qa.push_back('{32'h100, 5'd1, 32'h10, 3'd1});
    qa.push_back('{32'h101, 5'd2, 32'h14, 3'd2});
    qa.push_back('{32'h102, 5'd3, 32'h18, 3'd3});
    cpl(0, 2, 4'd2, 32'h102, 3'd0);
    cpl(0, 1, 4'd1, 32'h101, 3'd0);
    chk("ooo_head_wait", 32'(a_commit_valid), 0);
    set_cpl(0, 0, 4'd0, 32'h100, 3'd0);
    tick();
    clr_cpl();
    chk("ooo_first_commit_valid", 32'(a_commit_valid), 1);
    chk("ooo_first_commit_value", a_commit_value, 32'h100);
    tick(); tick(); tick();
    chk("ooo_drained_empty", 32'(a_empty), 1);
    chk("ooo_drained_count", 32'(a_count), 0);

    // Backpressure on commit
    a_commit_ready = 1'b0;
    alloc(0, 32'h20, 0, 5'd5, 3'd4);
    qa.push_back('{32'h200, 5'd5, 32'h20, 3'd4});
    cpl(0, 1, 4'd3, 32'h200, 3'd0);
    for (int k = 0; k < 3; k++) begin
      chk("bp_commit_valid", 32'(a_commit_valid), 1);
      chk("bp_count", 32'(a_count), 1);
      chk("bp_commit_pc", a_commit_pc, 32'h20);
      tick();
    end
    a_commit_ready = 1'b1;
    tick();
    chk("bp_release_count", 32'(a_count), 0);
    chk("bp_release_commit_valid", 32'(a_commit_valid), 0);

    // Exception at idx1 after idx0 retires
    do_reset();
    alloc(0, 32'h0FC, 32'h1FFC, 5'd1, 3'd0);
    alloc(0, 32'h100, 32'h2000, 5'd2, 3'd0);
    alloc(0, 32'h104, 32'h2004, 5'd3, 3'd0);
    alloc(0, 32'h108, 32'h2008, 5'd4, 3'd0);
    cpl(0, 0, 4'd1, 32'h55, 3'b010);
    qa.push_back('{32'h77, 5'd1, 32'h0FC, 3'd0});
    qf.push_back('{32'h100, 32'h2000, 3'b010});
    cpl(0, 1, 4'd0, 32'h77, 3'd0);
    chk("exc_head_flush_early", 32'(a_flush), 0);
    chk("exc_head_commit_valid", 32'(a_commit_valid), 1);
    tick();
    chk("exc_flush", 32'(a_flush), 1);
    chk("exc_flush_alloc_ready", 32'(a_alloc_ready), 0);
    chk("exc_flush_commit_valid", 32'(a_commit_valid), 0);
    a_alloc_valid = 1'b1;
    set_cpl(0, 2, 4'd2, 32'h99, 3'd0);
    tick();
    clr_cpl();
    a_alloc_valid = 1'b0;
    chk("exc_after_count", 32'(a_count), 0);
    chk("exc_after_empty", 32'(a_empty), 1);
    chk("exc_after_flush", 32'(a_flush), 0);
    chk("exc_after_alloc_idx", 32'(a_alloc_idx), 0);

    // Reset mid-run with 5 live entries
    for (int i = 0; i < 5; i++) begin
      alloc(0, 32'h500 + 32'(i), 0, 5'(i), 3'd0);
    end
    chk("mid_count_pre", 32'(a_count), 5);
    reset = 1'b1;
    a_alloc_valid = 1'b1;
    set_cpl(0, 0, 4'd0, 32'h1234, 3'd0);
    tick();
    reset = 1'b0;
    a_alloc_valid = 1'b0;
    clr_cpl();
    chk("mid_rst_count", 32'(a_count), 0);
    chk("mid_rst_empty", 32'(a_empty), 1);
    chk("mid_rst_commit_valid", 32'(a_commit_valid), 0);
    chk("mid_rst_alloc_idx", 32'(a_alloc_idx), 0);

    // Depth-10 instance: head/tail wrap 9 -> 0
    for (int i = 0; i < 11; i++) begin
      chk("wrap_alloc_idx", 32'(b_alloc_idx), 32'(i % 10));
      alloc(1, 32'h300 + 32'(i), 0, 5'(i), 3'(i % 8));
      qb.push_back('{32'h900 + 32'(i), 5'(i), 32'h300 + 32'(i), 3'(i % 8)});
      cpl(1, 1, 4'(i % 10), 32'h900 + 32'(i), 3'd0);
      tick();
    end
    chk("wrap_tail_after", 32'(b_alloc_idx), 1);
    chk("wrap_empty", 32'(b_empty), 1);

    // Completion to an invalid index changes nothing
    alloc(1, 32'h400, 0, 5'd7, 3'd2);
    cpl(1, 1, 4'd3, 32'hDEAD, 3'b111);
    chk("inv_commit_valid", 32'(b_commit_valid), 0);
    chk("inv_flush", 32'(b_flush), 0);
    chk("inv_count", 32'(b_count), 1);

    // Same-index collision: port 0 beats port 2
    qb.push_back('{32'hA, 5'd7, 32'h400, 3'd2});
    set_cpl(1, 0, 4'd1, 32'hA, 3'd0);
    set_cpl(1, 2, 4'd1, 32'hB, 3'd0);
    tick();
    clr_cpl();
    chk("coll_commit_value", b_commit_value, 32'hA);
    tick();
    chk("coll_empty", 32'(b_empty), 1);

    chk("a_scoreboard_drained", 32'(qa.size()), 0);
    chk("b_scoreboard_drained", 32'(qb.size()), 0);
    chk("flush_scoreboard_drained", 32'(qf.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
